// File: rtl/lsu_byte_master.sv
// Byte-serial load/store initiator: one request per handshake, one memory byte per cycle.
// Define MISALIGN_TRAP_EN to reject misaligned halfword/word requests instead of running them.
module lsu_byte_master #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       buf_q, buf_d;
    logic              err_q, err_d;

    logic              illegal;
    logic [1:0]        last_idx;
    logic [31:0]       load_ext;

    always_comb begin
        illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                  (req_we && req_funct3[2]);
`ifdef MISALIGN_TRAP_EN
        if ((req_funct3[1:0] == 2'b01) && req_addr[0])
            illegal = 1'b1;
        if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
            illegal = 1'b1;
`endif
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{buf_q[7]}}, buf_q[7:0]};
            3'b001:  load_ext = {{16{buf_q[15]}}, buf_q[15:0]};
            3'b100:  load_ext = {24'd0, buf_q[7:0]};
            3'b101:  load_ext = {16'd0, buf_q[15:0]};
            default: load_ext = buf_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        buf_d      = buf_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        mem_addr   = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = 8'd0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    idx_d    = 2'd0;
                    buf_d    = 32'd0;
                    err_d    = illegal;
                    state_d  = illegal ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                // Address add is naturally modulo 2^ADDR_W, giving wrap at the top of memory.
                mem_addr = addr_q + {{(ADDR_W-2){1'b0}}, idx_q};
                mem_re   = !we_q && !rst;
                mem_we   = we_q && !rst;
                if (we_q)
                    mem_wdata = wdata_q[{idx_q, 3'b000} +: 8];
                else
                    buf_d[{idx_q, 3'b000} +: 8] = mem_rdata;
                idx_d = idx_q + 2'd1;
                if (idx_q == last_idx)
                    state_d = RESP;
            end
            RESP: begin
                resp_valid = !rst;
                resp_err   = err_q;
                resp_rdata = (err_q || we_q) ? 32'd0 : load_ext;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            idx_q    <= 2'd0;
            buf_q    <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            idx_q    <= idx_d;
            buf_q    <= buf_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_byte_master.sv
// Testbench for lsu_byte_master: byte memory, transaction-level reference model, per-cycle compare.
// Honours MISALIGN_TRAP_EN the same way the design does.
module tb_lsu_byte_master;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    lsu_byte_master #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte-wide data memory seen by the design.
    logic [7:0] mem [256];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
    end

    typedef enum int {K_IDLE, K_ACC, K_RESP, K_RST} kind_t;
    typedef struct {
        kind_t       kind;
        logic        we;
        logic [7:0]  addr;
        logic [7:0]  wbyte;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] ref_mem [256];
    logic [7:0] obs_addr [8];
    logic [7:0] obs_wdata [8];
    int         vectors = 0;
    int         miscompares = 0;
    bit         checking = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int byteCount(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit isIllegal(input logic we, input logic [2:0] f3, input logic [7:0] a);
        bit bad;
        bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4);
`ifdef MISALIGN_TRAP_EN
        if (byteCount(f3) == 2 && (a % 2) != 0) bad = 1'b1;
        if (byteCount(f3) == 4 && (a % 4) != 0) bad = 1'b1;
`endif
        return bad;
    endfunction

    // Expected load value straight from the byte image: little-endian sum, then extension.
    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [7:0] a);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < byteCount(f3); i++)
            v = v + (32'(ref_mem[(int'(a) + i) % 256]) << (8 * i));
        if (f3 == 3'd0 && v >= 32'd128)   v = v + 32'hFFFFFF00;
        if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF0000;
        return v;
    endfunction

    task automatic driveJunk();
        req_valid  = 1'($urandom);
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = 8'($urandom);
        req_wdata  = $urandom;
    endtask

    // Compare every cycle against the next expected cycle; an empty queue means idle.
    always @(negedge clk) begin
        exp_t e;
        if (checking) begin
            if (expq.size() > 0) begin
                e = expq.pop_front();
            end else begin
                e = '{kind: K_IDLE, we: 1'b0, addr: 8'd0, wbyte: 8'd0, rdata: 32'd0, err: 1'b0};
            end
            case (e.kind)
                K_IDLE: begin
                    checkOutput("idle_req_ready", req_ready, 1);
                    checkOutput("idle_resp_valid", resp_valid, 0);
                    checkOutput("idle_mem_re", mem_re, 0);
                    checkOutput("idle_mem_we", mem_we, 0);
                end
                K_ACC: begin
                    checkOutput("acc_req_ready", req_ready, 0);
                    checkOutput("acc_resp_valid", resp_valid, 0);
                    checkOutput("acc_mem_re", mem_re, !e.we);
                    checkOutput("acc_mem_we", mem_we, e.we);
                    checkOutput("acc_mem_addr", mem_addr, e.addr);
                    if (e.we)
                        checkOutput("acc_mem_wdata", mem_wdata, e.wbyte);
                end
                K_RESP: begin
                    checkOutput("resp_req_ready", req_ready, 0);
                    checkOutput("resp_valid", resp_valid, 1);
                    checkOutput("resp_err", resp_err, e.err);
                    checkOutput("resp_rdata", resp_rdata, e.rdata);
                    checkOutput("resp_mem_re", mem_re, 0);
                    checkOutput("resp_mem_we", mem_we, 0);
                end
                default: begin
                    checkOutput("rst_mem_re", mem_re, 0);
                    checkOutput("rst_mem_we", mem_we, 0);
                    checkOutput("rst_resp_valid", resp_valid, 0);
                end
            endcase
        end
    end

    // Issue one request from an idle design; abort_k>0 raises rst after the k-th ACCESS cycle.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [7:0] a,
                                 input logic [31:0] wd, input int abort_k,
                                 output logic [31:0] rdata, output logic err, output int rcyc,
                                 output int nwe, output int nre);
        int n;
        int len;
        int wrote;
        bit ill;
        ill   = isIllegal(we, f3, a);
        n     = byteCount(f3);
        len   = ill ? 1 : n + 1;
        rdata = 32'd0;
        err   = 1'b0;
        rcyc  = -1;
        nwe   = 0;
        nre   = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        if (ill) begin
            expq.push_back('{kind: K_RESP, we: we, addr: 8'd0, wbyte: 8'd0, rdata: 32'd0, err: 1'b1});
        end else begin
            for (int i = 0; i < n; i++)
                expq.push_back('{kind: K_ACC, we: we, addr: 8'((int'(a) + i) % 256),
                                 wbyte: wd[8*i +: 8], rdata: 32'd0, err: 1'b0});
            expq.push_back('{kind: K_RESP, we: we, addr: 8'd0, wbyte: 8'd0,
                             rdata: we ? 32'd0 : modelLoad(f3, a), err: 1'b0});
            if (we) begin
                wrote = (abort_k > 0 && abort_k < n) ? abort_k : n;
                for (int i = 0; i < wrote; i++)
                    ref_mem[(int'(a) + i) % 256] = wd[8*i +: 8];
            end
        end
        #1;
        driveJunk();
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            obs_addr[c]  = mem_addr;
            obs_wdata[c] = mem_wdata;
            if (mem_we) nwe++;
            if (mem_re) nre++;
            if (resp_valid) begin
                rcyc  = c;
                rdata = resp_rdata;
                err   = resp_err;
            end
            @(posedge clk);
            #1;
            if (c == abort_k) begin
                rst = 1'b1;
                expq.delete();
                expq.push_back('{kind: K_RST, we: 1'b0, addr: 8'd0, wbyte: 8'd0, rdata: 32'd0, err: 1'b0});
                @(negedge clk);
                if (mem_we) nwe++;
                if (mem_re) nre++;
                if (resp_valid) rcyc = c + 1;
                @(posedge clk);
                #1;
                rst       = 1'b0;
                req_valid = 1'b0;
                break;
            end
            if (c < len) driveJunk();
            else req_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          rc;
        int          nw;
        int          nr;
        logic        we;
        logic [2:0]  f3;
        int          n;
        int          ab;

        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 8'd0;
        req_wdata  = 32'd0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", req_ready, 1);
        checkOutput("reset_resp_valid", resp_valid, 0);
        checkOutput("reset_resp_err", resp_err, 0);
        checkOutput("reset_resp_rdata", resp_rdata, 0);
        checkOutput("reset_mem_re", mem_re, 0);
        checkOutput("reset_mem_we", mem_we, 0);
        checkOutput("reset_mem_addr", mem_addr, 0);
        checkOutput("reset_mem_wdata", mem_wdata, 0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        checking = 1'b1;

        // Fill the whole memory with known data through aligned word stores.
        for (int j = 0; j < 64; j++)
            applyStimulus(1'b1, 3'b010, 8'(4 * j), $urandom, 0, rd, er, rc, nw, nr);

        applyStimulus(1'b1, 3'b010, 8'd12, 32'hFFFFAAAA, 0, rd, er, rc, nw, nr);
        applyStimulus(1'b0, 3'b010, 8'd12, 32'd0, 0, rd, er, rc, nw, nr);
        checkOutput("lw12_data", rd, 32'hFFFFAAAA);
        checkOutput("lw12_latency", rc, 5);
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("lw12_addr%0d", k), obs_addr[k + 1], 12 + k);

        applyStimulus(1'b0, 3'b001, 8'd12, 32'd0, 0, rd, er, rc, nw, nr);
        checkOutput("lh12_data", rd, 32'hFFFFAAAA);
        applyStimulus(1'b0, 3'b101, 8'd12, 32'd0, 0, rd, er, rc, nw, nr);
        checkOutput("lhu12_data", rd, 32'h0000AAAA);
        applyStimulus(1'b1, 3'b000, 8'd0, 32'h00000011, 0, rd, er, rc, nw, nr);
        applyStimulus(1'b0, 3'b000, 8'd0, 32'd0, 0, rd, er, rc, nw, nr);
        checkOutput("lb0_data", rd, 32'h00000011);
        applyStimulus(1'b0, 3'b100, 8'd12, 32'd0, 0, rd, er, rc, nw, nr);
        checkOutput("lbu12_data", rd, 32'h000000AA);

        applyStimulus(1'b1, 3'b010, 8'd4, 32'h12345678, 0, rd, er, rc, nw, nr);
        checkOutput("sw4_we_cycles", nw, 4);
        checkOutput("sw4_rdata", rd, 0);
        checkOutput("sw4_err", er, 0);
        checkOutput("sw4_byte0", obs_wdata[1], 32'h78);
        checkOutput("sw4_byte1", obs_wdata[2], 32'h56);
        checkOutput("sw4_byte2", obs_wdata[3], 32'h34);
        checkOutput("sw4_byte3", obs_wdata[4], 32'h12);
        applyStimulus(1'b0, 3'b010, 8'd4, 32'd0, 0, rd, er, rc, nw, nr);
        checkOutput("lw4_data", rd, 32'h12345678);

        applyStimulus(1'b1, 3'b001, 8'hFF, 32'h0000BEEF, 0, rd, er, rc, nw, nr);
`ifdef MISALIGN_TRAP_EN
        checkOutput("shff_err", er, 1);
        checkOutput("shff_we_cycles", nw, 0);
`else
        checkOutput("shff_err", er, 0);
        applyStimulus(1'b0, 3'b100, 8'hFF, 32'd0, 0, rd, er, rc, nw, nr);
        checkOutput("shff_byte_ff", rd, 32'h000000EF);
        applyStimulus(1'b0, 3'b100, 8'h00, 32'd0, 0, rd, er, rc, nw, nr);
        checkOutput("shff_byte_00", rd, 32'h000000BE);
`endif

        applyStimulus(1'b0, 3'b011, 8'd0, 32'd0, 0, rd, er, rc, nw, nr);
        checkOutput("bad_f3_latency", rc, 1);
        checkOutput("bad_f3_err", er, 1);
        checkOutput("bad_f3_rdata", rd, 0);
        checkOutput("bad_f3_re_cycles", nr, 0);
        @(negedge clk);
        checkOutput("bad_f3_ready_after", req_ready, 1);
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 3'b010, 8'd8, 32'hAABBCCDD, 1, rd, er, rc, nw, nr);
        checkOutput("abort_we_cycles", nw, 1);
        checkOutput("abort_no_resp", rc, -1);
        @(negedge clk);
        checkOutput("abort_ready_after", req_ready, 1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'b100, 8'd8, 32'd0, 0, rd, er, rc, nw, nr);
        checkOutput("abort_byte8", rd, 32'h000000DD);

        // Randomized traffic with occasional mid-access resets and idle gaps.
        for (int t = 0; t < 400; t++) begin
            we = 1'($urandom);
            f3 = 3'($urandom);
            n  = byteCount(f3);
            ab = 0;
            if (!isIllegal(we, f3, req_addr) && n > 1 && $urandom_range(0, 15) == 0)
                ab = $urandom_range(1, n - 1);
            req_addr = 8'($urandom);
            if (ab > 0 && isIllegal(we, f3, req_addr)) ab = 0;
            applyStimulus(we, f3, req_addr, $urandom, ab, rd, er, rc, nw, nr);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
